gpio_write_arbiter: RTL
=======================

# gpio_write_arbiter

Controller that shares the GPIO peripheral between two bus requesters, such as the CPU store path and a debug/monitor port. It serialises their 32-bit GPIO writes with round-robin arbitration and drives the GPIO write strobe. After each write it pulses the LED serial shifter start and waits for the shift to finish before acknowledging. When no writes arrive, it periodically re-triggers the shifter so the external LED chain is refreshed. It sits between the requesters and the GPIO block (EN, P_Data, Start) and observes the shifter busy flag.

## Interface
- REFRESH_CYCLES, 32'd50_000_000, idle cycles between automatic LED refreshes; 0 disables refresh
- BUSY_TIMEOUT, 16'd1024, max cycles to wait for shifter busy to rise after start
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0  input  1  requester 0 write request; held until ack0
- data0  input  32  requester 0 write data; stable while req0 high
- req1  input  1  requester 1 write request; held until ack1
- data1  input  32  requester 1 write data; stable while req1 high
- shift_busy  input  1  LED shifter busy (high while serial shift in progress)
- gpio_en  output  1  GPIO write strobe (to GPIO EN)
- gpio_data  output  32  GPIO write data (to GPIO P_Data)
- gpio_start  output  1  shifter start pulse (to GPIO Start)
- ack0  output  1  one-cycle completion pulse for requester 0
- ack1  output  1  one-cycle completion pulse for requester 1
- busy  output  1  high whenever FSM is not IDLE
- timeout_err  output  1  sticky: a shift never started within BUSY_TIMEOUT

## Operation
- All outputs are registered. Reset values: gpio_en=0, gpio_data=0, gpio_start=0, ack0=0, ack1=0, busy=0, timeout_err=0, state=IDLE, last_grant=1, refresh counter=0, timeout counter=0.
- FSM states: IDLE, WRITE, START, WAIT_HI, WAIT_LO, ACK.
- IDLE:
  - If any req: pick a winner. Only one req -> that one. Both -> the one that is not last_grant.
  - Latch the winner's id into grant and last_grant, latch its data into gpio_data, go to WRITE.
  - Else, if REFRESH_CYCLES!=0 and refresh counter == REFRESH_CYCLES-1: go to START with refresh flag set (no write, no ack).
  - Else increment refresh counter.
- WRITE: gpio_en=1 for exactly one cycle, then go to START.
- START: gpio_start=1 for exactly one cycle, clear timeout counter, then go to WAIT_HI.
- WAIT_HI:
  - shift_busy=1 -> go to WAIT_LO.
  - Timeout counter reaches BUSY_TIMEOUT-1 -> set timeout_err, go to ACK.
  - Otherwise increment timeout counter.
- WAIT_LO: stay while shift_busy=1; go to ACK when it reads 0. There is no timeout in this state.
- ACK:
  - If not a refresh: pulse ack[grant] for one cycle.
  - Clear the refresh flag and refresh counter, return to IDLE.
- Refresh counter is cleared whenever a transaction (write or refresh) starts. The counter is 32 bits wide and never wraps past REFRESH_CYCLES-1.
- gpio_data holds its last written value between transactions. A refresh re-shifts the current GPIO contents.
- Requester protocol: deassert req in the cycle after its ack is seen. A req still high in IDLE is treated as a new request.
- Requests arriving mid-transaction wait; they are evaluated in IDLE.

## Timing
- Write latency: req sampled in IDLE at edge N -> gpio_en high in cycle N+1 -> gpio_start in N+2 -> WAIT_HI from N+3.
- With a shifter whose busy rises 1 cycle after start and lasts B cycles, the ack appears about B+4 cycles after req is sampled.
- Minimum request-to-request spacing: 6 cycles (IDLE→WRITE→START→WAIT_HI→WAIT_LO→ACK→IDLE).
- Simultaneous req0 and req1: the winner alternates each grant. The first grant after reset goes to requester 0.
- A request and refresh expiry in the same IDLE cycle: the request wins and the refresh counter clears.
- Async reset mid-transaction: all outputs drop to their reset values immediately and no ack is issued. Requesters must re-request.
- gpio_en and gpio_start are never high in the same cycle. ack0 and ack1 are never high in the same cycle.

## Test plan
- Single write: req0=1 with data0=32'h0001_2A00, shifter busy for 16 cycles -> exactly one gpio_en cycle with gpio_data=32'h0001_2A00, one gpio_start pulse on the next cycle, ack0 pulse after busy falls, ack1 never asserted.
- Contention: req0 and req1 held together with distinct data for 4 transactions -> grant order 0,1,0,1, each gpio_data matching its grantee, no overlapping acks.
- Refresh: REFRESH_CYCLES=100, no requests -> gpio_start pulses every 100 idle cycles plus transaction length, gpio_en stays 0, no acks.
- Refresh collision: req1 asserted in the exact cycle refresh expires -> a write to requester 1 occurs, ack1 is issued, and the refresh counter restarts from 0.
- Timeout: shift_busy tied to 0, BUSY_TIMEOUT=8 -> ack0 arrives 8 cycles after WAIT_HI is entered, timeout_err=1 and stays 1 until rst.
- Reset mid-shift: rst asserted during WAIT_LO -> busy, gpio_en, gpio_start and acks go to 0 asynchronously. After release, first contended grant goes to requester 0.

Source files
------------

// File: rtl/gpio_write_arbiter.sv
// ---------------------------------------------------------------------------
// gpio_write_arbiter
//
// Shares the GPIO peripheral between two bus requesters. Writes are
// serialised with round-robin arbitration; each write strobes the GPIO
// register, kicks the LED serial shifter and waits for the shift to finish
// before acknowledging the requester. While no writes arrive the shifter is
// re-triggered periodically so the external LED chain stays refreshed.
//
// Parameters
//   REFRESH_CYCLES  idle cycles between automatic LED refreshes (0 = off)
//   BUSY_TIMEOUT    cycles to wait for shift_busy to rise after a start
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req0/data0      requester 0 write request (held until ack0) and data
//   req1/data1      requester 1 write request (held until ack1) and data
//   shift_busy      LED shifter busy flag
//   gpio_en         GPIO write strobe (GPIO EN)
//   gpio_data       GPIO write data (GPIO P_Data), holds last written value
//   gpio_start      shifter start pulse (GPIO Start)
//   ack0, ack1      one-cycle completion pulses per requester
//   busy            high whenever the controller is not idle
//   timeout_err     sticky flag: a shift never started in time
// ---------------------------------------------------------------------------
module gpio_write_arbiter #(
   parameter logic [31:0] REFRESH_CYCLES = 32'd50_000_000,
   parameter logic [15:0] BUSY_TIMEOUT   = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [31:0] data0,
   input  logic        req1,
   input  logic [31:0] data1,
   input  logic        shift_busy,
   output logic        gpio_en,
   output logic [31:0] gpio_data,
   output logic        gpio_start,
   output logic        ack0,
   output logic        ack1,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      START,
      WAIT_HI,
      WAIT_LO,
      ACK
   } state_t;

   state_t      state_q, state_d;
   logic        grant_q, grant_d;
   logic        lastGrant_q, lastGrant_d;
   logic        refresh_q, refresh_d;
   logic [31:0] refCnt_q, refCnt_d;
   logic [15:0] toCnt_q, toCnt_d;
   logic [31:0] gpioData_q, gpioData_d;
   logic        gpioEn_q, gpioEn_d;
   logic        gpioStart_q, gpioStart_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        busy_q, busy_d;
   logic        timeoutErr_q, timeoutErr_d;
   logic        winner;

   // Round-robin pick: a lone requester always wins; when both ask, the one
   // that was not served last time gets the bus. lastGrant resets to 1 so the
   // very first contended grant goes to requester 0.
   assign winner = (req0 && req1) ? ~lastGrant_q : req1;

   // Next-state logic for the transaction sequencer. Every output is a
   // registered copy of a function of the next state, so the strobes line up
   // exactly with the state the FSM is in during that cycle.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      lastGrant_d  = lastGrant_q;
      refresh_d    = refresh_q;
      refCnt_d     = refCnt_q;
      toCnt_d      = toCnt_q;
      gpioData_d   = gpioData_q;
      timeoutErr_d = timeoutErr_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant_d     = winner;
               lastGrant_d = winner;
               gpioData_d  = winner ? data1 : data0;
               refCnt_d    = 32'd0;
               state_d     = WRITE;
            end else if ((REFRESH_CYCLES != 32'd0) &&
                         (refCnt_q == REFRESH_CYCLES - 32'd1)) begin
               refresh_d = 1'b1;
               refCnt_d  = 32'd0;
               state_d   = START;
            end else if (REFRESH_CYCLES != 32'd0) begin
               refCnt_d = refCnt_q + 32'd1;
            end
         end
         WRITE: begin
            state_d = START;
         end
         START: begin
            toCnt_d = 16'd0;
            state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (shift_busy) begin
               state_d = WAIT_LO;
            end else if (toCnt_q == BUSY_TIMEOUT - 16'd1) begin
               timeoutErr_d = 1'b1;
               state_d      = ACK;
            end else begin
               toCnt_d = toCnt_q + 16'd1;
            end
         end
         WAIT_LO: begin
            if (!shift_busy) begin
               state_d = ACK;
            end
         end
         ACK: begin
            refresh_d = 1'b0;
            refCnt_d  = 32'd0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      gpioEn_d    = (state_d == WRITE);
      gpioStart_d = (state_d == START);
      ack0_d      = (state_d == ACK) && !refresh_d && !grant_d;
      ack1_d      = (state_d == ACK) && !refresh_d &&  grant_d;
      busy_d      = (state_d != IDLE);
   end

   // State and output registers. Reset drops every output at once so a
   // transaction in flight is abandoned without an acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         lastGrant_q  <= 1'b1;
         refresh_q    <= 1'b0;
         refCnt_q     <= 32'd0;
         toCnt_q      <= 16'd0;
         gpioData_q   <= 32'd0;
         gpioEn_q     <= 1'b0;
         gpioStart_q  <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         busy_q       <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         lastGrant_q  <= lastGrant_d;
         refresh_q    <= refresh_d;
         refCnt_q     <= refCnt_d;
         toCnt_q      <= toCnt_d;
         gpioData_q   <= gpioData_d;
         gpioEn_q     <= gpioEn_d;
         gpioStart_q  <= gpioStart_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         busy_q       <= busy_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   assign gpio_en     = gpioEn_q;
   assign gpio_data   = gpioData_q;
   assign gpio_start  = gpioStart_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign busy        = busy_q;
   assign timeout_err = timeoutErr_q;

endmodule
